// File: rtl/fetch_unit_if.sv
// Instruction-memory bus: fetch_unit is the master, instruction_mem the slave.
interface fetch_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] add_im;
  logic              we_im;
  logic [DATA_W-1:0] data_im_in;
  logic [DATA_W-1:0] out_im;

  modport master (output add_im, we_im, data_im_in, input out_im);
  modport slave  (input add_im, we_im, data_im_in, output out_im);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: program loader plus sequential fetch with branch/stall/halt.
// Optional stall/bubble performance counter is built when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start_run,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  fetch_unit_if.master      im,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy,
  output logic [15:0]       perf_stall_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] add_q, add_nxt;
  logic              we_q, we_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [ADDR_W-1:0] ld_ptr, ld_ptr_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic              rd_vld, rd_vld_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic              instr_valid_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              halted_nxt, busy_nxt, load_ready_nxt;
  logic [ADDR_W-1:0] pend;

  assign im.add_im     = add_q;
  assign im.we_im      = we_q;
  assign im.data_im_in = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      add_q       <= RESET_PC;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ld_ptr      <= '0;
      rd_addr     <= RESET_PC;
      rd_vld      <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      busy        <= 1'b0;
      load_ready  <= 1'b0;
    end else begin
      state       <= state_nxt;
      add_q       <= add_nxt;
      we_q        <= we_nxt;
      wdata_q     <= wdata_nxt;
      ld_ptr      <= ld_ptr_nxt;
      rd_addr     <= rd_addr_nxt;
      rd_vld      <= rd_vld_nxt;
      instr       <= instr_nxt;
      instr_valid <= instr_valid_nxt;
      pc          <= pc_nxt;
      halted      <= halted_nxt;
      busy        <= busy_nxt;
      load_ready  <= load_ready_nxt;
    end
  end

  // rd_addr is the next word to capture; rd_vld says out_im currently holds mem[rd_addr].
  always_comb begin
    state_nxt       = state;
    add_nxt         = add_q;
    we_nxt          = 1'b0;
    wdata_nxt       = wdata_q;
    ld_ptr_nxt      = ld_ptr;
    rd_addr_nxt     = rd_addr;
    rd_vld_nxt      = rd_vld;
    instr_nxt       = instr;
    instr_valid_nxt = instr_valid;
    pc_nxt          = pc;
    halted_nxt      = halted;
    busy_nxt        = busy;
    load_ready_nxt  = load_ready;
    pend            = rd_addr;

    case (state)
      IDLE, HALT: begin
        if (state == HALT && !stall) instr_valid_nxt = 1'b0;
        if (start_load) begin
          state_nxt       = LOAD;
          ld_ptr_nxt      = '0;
          load_ready_nxt  = 1'b1;
          busy_nxt        = 1'b1;
          halted_nxt      = 1'b0;
          instr_valid_nxt = 1'b0;
        end else if (start_run) begin
          state_nxt       = RUN;
          add_nxt         = RESET_PC;
          rd_addr_nxt     = RESET_PC;
          rd_vld_nxt      = 1'b0;
          busy_nxt        = 1'b1;
          halted_nxt      = 1'b0;
          instr_valid_nxt = 1'b0;
        end
      end

      LOAD: begin
        if (load_valid && load_ready) begin
          we_nxt     = 1'b1;
          add_nxt    = ld_ptr;
          wdata_nxt  = load_data;
          ld_ptr_nxt = ld_ptr + ADDR_W'(1);
          if (load_last) begin
            state_nxt      = IDLE;
            load_ready_nxt = 1'b0;
            busy_nxt       = 1'b0;
          end
        end
      end

      RUN: begin
        if (br_taken && instr_valid) begin
          add_nxt         = br_target;
          rd_addr_nxt     = br_target;
          rd_vld_nxt      = 1'b0;
          instr_valid_nxt = 1'b0;
        end else if (stall && instr_valid) begin
          // Re-read the pending word; it is back on out_im once add_q points at it.
          add_nxt    = rd_addr;
          rd_vld_nxt = (add_q == rd_addr);
        end else begin
          instr_valid_nxt = rd_vld;
          if (rd_vld) begin
            instr_nxt = im.out_im;
            pc_nxt    = rd_addr;
            pend      = rd_addr + ADDR_W'(1);
          end
          rd_addr_nxt = pend;
          rd_vld_nxt  = (add_q == pend);
          add_nxt     = add_q + ADDR_W'(1);
          if (rd_vld && im.out_im[DATA_W-1 -: 4] == HALT_OP) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
            busy_nxt   = 1'b0;
            add_nxt    = add_q;
            rd_vld_nxt = 1'b0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;

  // Counts RUN cycles in which decode gets no new instruction; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == IDLE || state == HALT) && start_run && !start_load) begin
      stall_cnt <= '0;
    end else if (state == RUN && (stall || !instr_valid) && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural 1-cycle-latency instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_load, load_valid, load_last, load_ready;
  logic [15:0] load_data;
  logic        start_run, stall, br_taken;
  logic [11:0] br_target;
  logic [15:0] instr;
  logic        instr_valid;
  logic [11:0] pc;
  logic        halted, busy;
  logic [15:0] perf_stall_cnt;
  int          checks = 0;
  int          errors = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  fetch_unit_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .start_load(start_load), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .start_run(start_run), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .im(bus),
    .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .halted(halted), .busy(busy), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];

  // Read-before-write synchronous memory
  always @(posedge clk) begin
    if (bus.we_im) mem[bus.add_im] <= bus.data_im_in;
    bus.out_im <= mem[bus.add_im];
  end

  task automatic applyStimulus(input logic sl, input logic lv, input logic [15:0] ld,
                               input logic ll, input logic sr, input logic st,
                               input logic bt, input logic [11:0] btgt);
    start_load = sl; load_valid = lv; load_data = ld; load_last = ll;
    start_run = sr; stall = st; br_taken = bt; br_target = btgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 12'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    rst_n = 1'b0;
    start_load = 0; load_valid = 0; load_data = '0; load_last = 0;
    start_run = 0; stall = 0; br_taken = 0; br_target = '0;
    #12;
    checkOutput("rst_we", bus.we_im, 0);
    checkOutput("rst_add", bus.add_im, 12'h000);
    checkOutput("rst_ready", load_ready, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_perf", perf_stall_cnt, 0);
    rst_n = 1'b1;

    $display("[TB] reset mid-load");
    applyStimulus(1, 0, 16'h0, 0, 0, 0, 0, 12'h0);
    checkOutput("ld_ready", load_ready, 1);
    checkOutput("ld_busy", busy, 1);
    applyStimulus(0, 1, 16'h1111, 0, 0, 0, 0, 12'h0);
    applyStimulus(0, 1, 16'h2222, 0, 0, 0, 0, 12'h0);
    checkOutput("ld2_we", bus.we_im, 1);
    checkOutput("ld2_add", bus.add_im, 12'h001);
    load_valid = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_we", bus.we_im, 0);
    checkOutput("midrst_ready", load_ready, 0);
    idle();
    checkOutput("midrst_add", bus.add_im, 12'h000);
    checkOutput("midrst_busy", busy, 0);
    rst_n = 1'b1;

    $display("[TB] program load");
    applyStimulus(1, 0, 16'h0, 0, 0, 0, 0, 12'h0);
    applyStimulus(0, 1, 16'h02A3, 0, 0, 0, 0, 12'h0);
    checkOutput("w0_we", bus.we_im, 1);
    checkOutput("w0_add", bus.add_im, 12'h000);
    checkOutput("w0_data", bus.data_im_in, 16'h02A3);
    applyStimulus(0, 1, 16'h00FF, 0, 0, 0, 0, 12'h0);
    checkOutput("w1_add", bus.add_im, 12'h001);
    checkOutput("w1_data", bus.data_im_in, 16'h00FF);
    applyStimulus(0, 1, 16'hF000, 1, 0, 0, 0, 12'h0);
    checkOutput("w2_we", bus.we_im, 1);
    checkOutput("w2_add", bus.add_im, 12'h002);
    checkOutput("w2_ready", load_ready, 0);
    checkOutput("w2_busy", busy, 0);
    idle();
    checkOutput("ld_done_we", bus.we_im, 0);

    $display("[TB] sequential run");
    applyStimulus(0, 0, 16'h0, 0, 1, 0, 0, 12'h0);
    checkOutput("r_e0_valid", instr_valid, 0);
    checkOutput("r_e0_busy", busy, 1);
    idle();
    checkOutput("r_e1_valid", instr_valid, 0);
    idle();
    checkOutput("r_e2_instr", instr, 16'h02A3);
    checkOutput("r_e2_pc", pc, 12'h000);
    checkOutput("r_e2_valid", instr_valid, 1);
    idle();
    checkOutput("r_e3_instr", instr, 16'h00FF);
    checkOutput("r_e3_pc", pc, 12'h001);
    idle();
    checkOutput("r_e4_instr", instr, 16'hF000);
    checkOutput("r_e4_pc", pc, 12'h002);
    checkOutput("r_e4_halted", halted, 1);
    checkOutput("r_e4_valid", instr_valid, 1);
    checkOutput("r_e4_perf", perf_stall_cnt, PERF_ON ? 2 : 0);
    idle();
    checkOutput("r_e5_valid", instr_valid, 0);
    checkOutput("r_e5_add", bus.add_im, 12'h003);
    checkOutput("r_e5_busy", busy, 0);

    $display("[TB] stall replay");
    applyStimulus(0, 0, 16'h0, 0, 1, 0, 0, 12'h0);
    checkOutput("s_perf_clr", perf_stall_cnt, 0);
    checkOutput("s_halted_clr", halted, 0);
    idle();
    idle();
    idle();
    checkOutput("s_pre_pc", pc, 12'h001);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 16'h0, 0, 0, 1, 0, 12'h0);
      checkOutput("s_hold_instr", instr, 16'h00FF);
      checkOutput("s_hold_pc", pc, 12'h001);
    end
    idle();
    checkOutput("s_drop_instr", instr, 16'hF000);
    checkOutput("s_drop_pc", pc, 12'h002);
    checkOutput("s_drop_halted", halted, 1);
    checkOutput("s_perf", perf_stall_cnt, PERF_ON ? 5 : 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 1, 0, 12'h0);
    checkOutput("h_stall_valid", instr_valid, 1);
    idle();
    checkOutput("h_nostall_valid", instr_valid, 0);

    $display("[TB] branch redirect");
    applyStimulus(0, 0, 16'h0, 0, 1, 0, 0, 12'h0);
    idle();
    idle();
    checkOutput("b_pre_pc", pc, 12'h000);
    applyStimulus(0, 0, 16'h0, 0, 0, 0, 1, 12'h002);
    checkOutput("b_bub1", instr_valid, 0);
    idle();
    checkOutput("b_bub2", instr_valid, 0);
    idle();
    checkOutput("b_instr", instr, 16'hF000);
    checkOutput("b_pc", pc, 12'h002);
    checkOutput("b_halted", halted, 1);
    checkOutput("b_perf", perf_stall_cnt, PERF_ON ? 4 : 0);

    $display("[TB] perf run with 4 stalls");
    applyStimulus(0, 0, 16'h0, 0, 1, 0, 0, 12'h0);
    idle();
    idle();
    idle();
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 16'h0, 0, 0, 1, 0, 12'h0);
    checkOutput("p_hold_pc", pc, 12'h001);
    idle();
    checkOutput("p_halted", halted, 1);
    checkOutput("p_perf", perf_stall_cnt, PERF_ON ? 6 : 0);

    $display("[TB] single-cycle stall");
    applyStimulus(0, 0, 16'h0, 0, 1, 0, 0, 12'h0);
    idle();
    idle();
    applyStimulus(0, 0, 16'h0, 0, 0, 1, 0, 12'h0);
    checkOutput("q_hold_pc", pc, 12'h000);
    idle();
    checkOutput("q_gap_valid", instr_valid, 0);
    idle();
    checkOutput("q_next_instr", instr, 16'h00FF);
    checkOutput("q_next_pc", pc, 12'h001);
    idle();
    checkOutput("q_halt_instr", instr, 16'hF000);
    checkOutput("q_halted", halted, 1);

    $display("[TB] simultaneous start pulses");
    applyStimulus(1, 0, 16'h0, 0, 1, 0, 0, 12'h0);
    checkOutput("both_ready", load_ready, 1);
    checkOutput("both_halted", halted, 0);
    checkOutput("both_valid", instr_valid, 0);
    applyStimulus(0, 1, 16'h0123, 1, 0, 0, 0, 12'h0);
    checkOutput("both_we", bus.we_im, 1);
    checkOutput("both_add", bus.add_im, 12'h000);
    checkOutput("both_ready_end", load_ready, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
